// File: rtl/mst_chk_mdl_if.sv
// simple_if: single-port memory bus between a master and a slave.
// The master drives addr/rd_req/wr_req/wr_data; the slave returns rd_data.
interface simple_if #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8
);
  logic [ADDR_BIT_WIDTH-1:0] addr;
  logic                      rd_req;
  logic                      wr_req;
  logic [DATA_BIT_WIDTH-1:0] wr_data;
  logic [DATA_BIT_WIDTH-1:0] rd_data;

  modport mst_port (output addr, rd_req, wr_req, wr_data, input rd_data);
  modport slv_port (input addr, rd_req, wr_req, wr_data, output rd_data);
endinterface

// File: rtl/mst_chk_mdl.sv
// mst_chk_mdl: write/read-back traffic generator and checker for a simple_if
// slave. Each pass writes a pattern to every address, reads it all back and
// compares; passes repeat a programmed number of times or endlessly.
module mst_chk_mdl #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int RD_LATENCY     = 1,
  parameter int PASS_CNT_WIDTH = 16,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_sync_rst,
  input  logic                      i_start,
  input  logic                      i_pattern_sel,
  input  logic [PASS_CNT_WIDTH-1:0] i_num_passes,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [PASS_CNT_WIDTH-1:0] o_pass_cnt,
  output logic [ERR_CNT_WIDTH-1:0]  o_err_cnt,
  output logic                      o_err_flag,
  output logic [ADDR_BIT_WIDTH-1:0] o_first_err_addr,
  simple_if.mst_port                if_bus
);
  localparam logic [ADDR_BIT_WIDTH-1:0] MAX_ADDR = '1;
  localparam int DCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_nxt;

  logic                      sel_q, sel_nxt;
  logic [PASS_CNT_WIDTH-1:0] num_q;
  logic [DATA_BIT_WIDTH-1:0] p_q, p_nxt;
  logic [DCW-1:0]            drain_q;
  logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_nxt;
  logic                      wr_req_q, wr_req_nxt, rd_req_q, rd_req_nxt;
  logic [DATA_BIT_WIDTH-1:0] wr_data_q, wr_data_nxt, pat_nxt;
  logic                      start_go, drain_end, last_pass, mismatch;

  // Compare pipeline: stage 0 tracks the read now on the bus, stage
  // RD_LATENCY lines up with the returning rd_data.
  logic [RD_LATENCY:0]       vld_pipe;
  logic [DATA_BIT_WIDTH-1:0] exp_pipe [RD_LATENCY:0];
  logic [ADDR_BIT_WIDTH-1:0] adr_pipe [RD_LATENCY:0];

  function automatic logic [DATA_BIT_WIDTH-1:0] pat_fn(
    input logic [ADDR_BIT_WIDTH-1:0] a,
    input logic [DATA_BIT_WIDTH-1:0] p,
    input logic                      inv
  );
    logic [DATA_BIT_WIDTH-1:0] v;
    v = DATA_BIT_WIDTH'(a) + p;
    return inv ? ~v : v;
  endfunction

  assign start_go  = ((state_q == IDLE) || (state_q == DONE)) && i_start;
  assign drain_end = (state_q == DRAIN) && (drain_q == DRAIN_LAST);
  assign last_pass = (num_q != '0) && ((o_pass_cnt + 1'b1) == num_q);
  assign mismatch  = vld_pipe[RD_LATENCY] && (if_bus.rd_data != exp_pipe[RD_LATENCY]);

  assign if_bus.addr    = addr_q;
  assign if_bus.wr_req  = wr_req_q;
  assign if_bus.rd_req  = rd_req_q;
  assign if_bus.wr_data = wr_data_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) state_q <= IDLE;
    else            state_q <= state_nxt;
  end

  // Next-state: sweep writes, sweep reads, wait out the read latency
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE, DONE: if (i_start) state_nxt = WRITE;
      WRITE:      if (addr_q == MAX_ADDR) state_nxt = READ;
      READ:       if (addr_q == MAX_ADDR) state_nxt = DRAIN;
      DRAIN:      if (drain_q == DRAIN_LAST) state_nxt = last_pass ? DONE : WRITE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output decode: next-cycle bus values, registered below with the state
  always_comb begin
    sel_nxt     = start_go ? i_pattern_sel : sel_q;
    p_nxt       = start_go ? '0 : (drain_end ? p_q + 1'b1 : p_q);
    addr_nxt    = '0;
    wr_req_nxt  = 1'b0;
    rd_req_nxt  = 1'b0;
    unique case (state_nxt)
      WRITE: begin
        wr_req_nxt = 1'b1;
        addr_nxt   = (state_q == WRITE) ? addr_q + 1'b1 : '0;
      end
      READ: begin
        rd_req_nxt = 1'b1;
        addr_nxt   = (state_q == READ) ? addr_q + 1'b1 : '0;
      end
      default: ;
    endcase
    pat_nxt     = pat_fn(addr_nxt, p_nxt, sel_nxt);
    wr_data_nxt = wr_req_nxt ? pat_nxt : '0;
  end

  // Registered outputs, pass bookkeeping and error accounting
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      addr_q           <= '0;
      wr_req_q         <= 1'b0;
      rd_req_q         <= 1'b0;
      wr_data_q        <= '0;
      sel_q            <= 1'b0;
      p_q              <= '0;
      num_q            <= '0;
      drain_q          <= '0;
      vld_pipe         <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass_cnt       <= '0;
      o_err_cnt        <= '0;
      o_err_flag       <= 1'b0;
      o_first_err_addr <= '0;
    end else begin
      addr_q    <= addr_nxt;
      wr_req_q  <= wr_req_nxt;
      rd_req_q  <= rd_req_nxt;
      wr_data_q <= wr_data_nxt;
      sel_q     <= sel_nxt;
      p_q       <= p_nxt;
      drain_q   <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
      vld_pipe  <= {vld_pipe[RD_LATENCY-1:0], rd_req_nxt};
      o_busy    <= state_nxt inside {WRITE, READ, DRAIN};
      o_done    <= (state_nxt == DONE);
      if (start_go) begin
        num_q            <= i_num_passes;
        o_pass_cnt       <= '0;
        o_err_cnt        <= '0;
        o_err_flag       <= 1'b0;
        o_first_err_addr <= '0;
      end else begin
        if (drain_end) o_pass_cnt <= o_pass_cnt + 1'b1;
        if (mismatch) begin
          if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
          if (!o_err_flag) begin
            o_err_flag       <= 1'b1;
            o_first_err_addr <= adr_pipe[RD_LATENCY];
          end
        end
      end
    end
  end

  // Expected data/address ride alongside vld_pipe; validity qualifies them
  always_ff @(posedge i_clk) begin
    exp_pipe[0] <= pat_nxt;
    adr_pipe[0] <= addr_nxt;
    for (int k = 1; k <= RD_LATENCY; k++) begin
      exp_pipe[k] <= exp_pipe[k-1];
      adr_pipe[k] <= adr_pipe[k-1];
    end
  end
endmodule

// File: tb/tb_mst_chk_mdl.sv
// Bench for mst_chk_mdl: two instances (1-cycle latency / 16-bit error count,
// 3-cycle latency / 2-bit error count) each against a memory model.
module tb_mst_chk_mdl;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int PW = 16;
  localparam int N  = 1 << AW;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] dat;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0]    rst, start, psel, busy, done, eflag;
  logic [PW-1:0] npass [2];
  logic [PW-1:0] pc0, pc1;
  logic [15:0]   ec0;
  logic [1:0]    ec1;
  logic [AW-1:0] fa0, fa1;
  logic [PW-1:0] pcnt [2];
  logic [15:0]   ecnt [2];
  logic [AW-1:0] faddr [2];
  assign pcnt[0] = pc0;  assign pcnt[1] = pc1;
  assign ecnt[0] = ec0;  assign ecnt[1] = {14'b0, ec1};
  assign faddr[0] = fa0; assign faddr[1] = fa1;

  simple_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) bif0 ();
  simple_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) bif1 ();

  logic [1:0]    wrq, rdq;
  logic [AW-1:0] baddr [2];
  logic [DW-1:0] bwd [2];
  assign wrq[0] = bif0.wr_req;  assign wrq[1] = bif1.wr_req;
  assign rdq[0] = bif0.rd_req;  assign rdq[1] = bif1.rd_req;
  assign baddr[0] = bif0.addr;  assign baddr[1] = bif1.addr;
  assign bwd[0] = bif0.wr_data; assign bwd[1] = bif1.wr_data;

  mst_chk_mdl #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .RD_LATENCY(1),
                .PASS_CNT_WIDTH(PW), .ERR_CNT_WIDTH(16)) u_dut0 (
    .i_clk(clk), .i_sync_rst(rst[0]), .i_start(start[0]), .i_pattern_sel(psel[0]),
    .i_num_passes(npass[0]), .o_busy(busy[0]), .o_done(done[0]), .o_pass_cnt(pc0),
    .o_err_cnt(ec0), .o_err_flag(eflag[0]), .o_first_err_addr(fa0), .if_bus(bif0));

  mst_chk_mdl #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .RD_LATENCY(3),
                .PASS_CNT_WIDTH(PW), .ERR_CNT_WIDTH(2)) u_dut1 (
    .i_clk(clk), .i_sync_rst(rst[1]), .i_start(start[1]), .i_pattern_sel(psel[1]),
    .i_num_passes(npass[1]), .o_busy(busy[1]), .o_done(done[1]), .o_pass_cnt(pc1),
    .o_err_cnt(ec1), .o_err_flag(eflag[1]), .o_first_err_addr(fa1), .if_bus(bif1));

  function automatic int lat(input int d);
    return (d == 1) ? 3 : 1;
  endfunction
  function automatic int err_max(input int d);
    return (d == 1) ? 3 : 65535;
  endfunction

  // Memory models: cmode 0 = ideal, 1 = corrupt one address, 2 = corrupt all
  int cmode [2];
  int cbad  [2];
  logic [DW-1:0] mem   [2][N];
  logic [DW-1:0] rpipe [2][3];
  assign bif0.rd_data = rpipe[0][0];
  assign bif1.rd_data = rpipe[1][2];

  function automatic bit corrupt(input int d, input int a);
    return (cmode[d] == 2) || (cmode[d] == 1 && cbad[d] == a);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wrq[d]) mem[d][baddr[d]] <= bwd[d];
      rpipe[d][0] <= rdq[d] ? (mem[d][baddr[d]] ^ (corrupt(d, int'(baddr[d])) ? 8'h01 : 8'h00)) : 8'h00;
      rpipe[d][1] <= rpipe[d][0];
      rpipe[d][2] <= rpipe[d][1];
    end
  end

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h required %0h (cycle %0d)", d, nm, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected bus transactions, filled at each start
  sb_t exp_q [2][$];
  sb_t mon_e;

  task automatic push_exp(input int d, input int s, input bit pat, input int passes);
    int pl;
    sb_t e;
    logic [DW-1:0] v;
    pl = 2 * N + lat(d);
    for (int p = 0; p < passes; p++) begin
      for (int a = 0; a < N; a++) begin
        v = DW'((a + p) % 256);
        e.cyc = s + p * pl + a; e.wr = 1'b1; e.a = AW'(a); e.dat = pat ? ~v : v;
        exp_q[d].push_back(e);
      end
      for (int a = 0; a < N; a++) begin
        e.cyc = s + p * pl + N + a; e.wr = 1'b0; e.a = AW'(a); e.dat = '0;
        exp_q[d].push_back(e);
      end
    end
  endtask

  // Bus monitor: pops expectations whenever a request is on the bus
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk(d, "wr_rd_exclusive", 32'(wrq[d] & rdq[d]), 32'd0);
      if (wrq[d] || rdq[d]) begin
        if (exp_q[d].size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dut%0d unexpected_txn: got wr=%0d rd=%0d addr=%0d at cycle %0d, required none",
                   d, wrq[d], rdq[d], baddr[d], cyc);
        end else begin
          mon_e = exp_q[d].pop_front();
          chk(d, "txn_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk(d, "txn_is_write", 32'(wrq[d]), 32'(mon_e.wr));
          chk(d, "txn_addr", 32'(baddr[d]), 32'(mon_e.a));
          if (mon_e.wr) chk(d, "wr_data", 32'(bwd[d]), 32'(mon_e.dat));
        end
      end else begin
        chk(d, "idle_addr", 32'(baddr[d]), 32'd0);
        chk(d, "idle_wr_data", 32'(bwd[d]), 32'd0);
      end
    end
  end

  task automatic chk_idle(input int d);
    chk(d, "rst_busy", 32'(busy[d]), 0);
    chk(d, "rst_done", 32'(done[d]), 0);
    chk(d, "rst_pass_cnt", 32'(pcnt[d]), 0);
    chk(d, "rst_err_cnt", 32'(ecnt[d]), 0);
    chk(d, "rst_err_flag", 32'(eflag[d]), 0);
    chk(d, "rst_first_addr", 32'(faddr[d]), 0);
    chk(d, "rst_wr_req", 32'(wrq[d]), 0);
    chk(d, "rst_rd_req", 32'(rdq[d]), 0);
    chk(d, "rst_addr", 32'(baddr[d]), 0);
    chk(d, "rst_wr_data", 32'(bwd[d]), 0);
  endtask

  task automatic do_start(input int d, input bit pat, input int passes, output int s);
    @(posedge clk); #1;
    start[d] = 1'b1; psel[d] = pat; npass[d] = PW'(passes);
    @(posedge clk); #1;
    start[d] = 1'b0;
    s = cyc;
    push_exp(d, s, pat, passes);
  endtask

  task automatic run(input int d, input bit pat, input int passes, input int cm, input int bad);
    int s, pl, t, ncor, e_err;
    bit got;
    cmode[d] = cm; cbad[d] = bad;
    do_start(d, pat, passes, s);
    pl = 2 * N + lat(d);
    got = 0; t = 0;
    for (int i = 0; i < passes * pl + 20; i++) begin
      if (done[d]) begin got = 1; t = cyc; break; end
      @(posedge clk); #1;
    end
    chk(d, "done_seen", 32'(got), 1);
    if (got) chk(d, "done_cycle", 32'(t), 32'(s + passes * pl));
    ncor  = (cm == 0) ? 0 : ((cm == 1) ? 1 : N);
    e_err = passes * ncor;
    if (e_err > err_max(d)) e_err = err_max(d);
    chk(d, "pass_cnt", 32'(pcnt[d]), 32'(passes));
    chk(d, "err_cnt", 32'(ecnt[d]), 32'(e_err));
    chk(d, "err_flag", 32'(eflag[d]), 32'(ncor != 0));
    chk(d, "first_err_addr", 32'(faddr[d]), 32'((cm == 1) ? bad : 0));
    chk(d, "busy_at_done", 32'(busy[d]), 0);
    chk(d, "txns_left", 32'(exp_q[d].size()), 0);
    cmode[d] = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, pl;
    rst = 2'b11; start = 2'b00; psel = 2'b00;
    npass[0] = '0; npass[1] = '0;
    cmode[0] = 0; cmode[1] = 0; cbad[0] = 0; cbad[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle(0); chk_idle(1);
    rst = 2'b00;

    run(0, 1'b0, 2, 0, 0);
    run(0, 1'b1, 1, 0, 0);
    run(0, 1'b0, 3, 1, 2);

    // Reset in the middle of pass 1's read sweep with corrupted reads in flight
    cmode[0] = 2;
    do_start(0, 1'b0, 2, s);
    pl = 2 * N + lat(0);
    while (cyc < s + pl + N + 1) begin @(posedge clk); #1; end
    rst[0] = 1'b1;
    @(posedge clk); #1;
    chk_idle(0);
    exp_q[0].delete();
    rst[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk(0, "post_rst_err_cnt", 32'(ecnt[0]), 0);
    chk(0, "post_rst_err_flag", 32'(eflag[0]), 0);
    chk(0, "post_rst_busy", 32'(busy[0]), 0);
    cmode[0] = 0;
    run(0, 1'b0, 2, 0, 0);

    run(1, 1'b0, 2, 0, 0);
    run(1, 1'b1, 3, 1, 3);

    // Endless mode against an always-wrong slave; start pulses while busy
    cmode[1] = 2;
    do_start(1, 1'b0, 0, s);
    exp_q[1].delete();
    push_exp(1, s, 1'b0, 4);
    pl = 2 * N + lat(1);
    while (cyc < s + 3 * pl) begin
      if (((cyc - s) % 7) == 3) begin
        start[1] = 1'b1; psel[1] = 1'b1; npass[1] = 16'd1;
      end else begin
        start[1] = 1'b0;
      end
      @(posedge clk); #1;
    end
    start[1] = 1'b0;
    chk(1, "endless_pass_cnt", 32'(pcnt[1]), 3);
    chk(1, "endless_err_sat", 32'(ecnt[1]), 3);
    chk(1, "endless_err_flag", 32'(eflag[1]), 1);
    chk(1, "endless_first_addr", 32'(faddr[1]), 0);
    chk(1, "endless_done", 32'(done[1]), 0);
    chk(1, "endless_busy", 32'(busy[1]), 1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk_idle(1);
    exp_q[1].delete();
    rst[1] = 1'b0;
    cmode[1] = 0;

    for (int it = 0; it < 6; it++) begin
      run(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mst_chk_mdl.md
# mst_chk_mdl

Parametrised bus-master traffic generator and checker for the simple slave memory interface. On `i_start` it writes every address with a selectable data pattern, reads every address back, compares each returned word against the expected value, and repeats for a programmable number of passes (or endlessly). It reports pass count, error count and first failing address. It sits in simulation benches and bring-up designs as the stimulus/self-check master in front of any `simple_if` slave.

## Interface
Parameters:
- `ADDR_BIT_WIDTH`, 2: address bit width; the swept range is 0..2**ADDR_BIT_WIDTH-1.
- `DATA_BIT_WIDTH`, 8: data bit width.
- `RD_LATENCY`, 1: cycles from a `rd_req` cycle to valid `rd_data`; must be ≥1.
- `PASS_CNT_WIDTH`, 16: width of the pass-count request and report.
- `ERR_CNT_WIDTH`, 16: width of the error counter, which saturates.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1: clock.
- `i_sync_rst` in 1: synchronous active-high reset.
- `i_start` in 1: start request; sampled only in IDLE or DONE.
- `i_pattern_sel` in 1: 0 = incremental, 1 = inverted incremental; latched at start.
- `i_num_passes` in PASS_CNT_WIDTH: number of passes; 0 = endless; latched at start.
- `o_busy` in/out: out, 1: high in WRITE, READ and DRAIN.
- `o_done` out 1: high while in DONE.
- `o_pass_cnt` out PASS_CNT_WIDTH: completed passes since the last start; wraps in endless mode.
- `o_err_cnt` out ERR_CNT_WIDTH: mismatches since the last start; saturates at all-ones.
- `o_err_flag` out 1: sticky; set on the first mismatch.
- `o_first_err_addr` out ADDR_BIT_WIDTH: address of the first mismatch; valid when `o_err_flag` is high.
- `if_bus` `simple_if.mst_port`: the master drives `addr`, `rd_req`, `wr_req` and `wr_data`; the slave returns `rd_data`.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE → WRITE when `i_start` is high.
  - WRITE → READ after the write at MAX_ADDR.
  - READ → DRAIN after the read at MAX_ADDR.
  - DRAIN lasts RD_LATENCY cycles. It then goes → WRITE if more passes remain (or endless mode), else → DONE.
  - DONE → WRITE when `i_start` is high.
- On start (from IDLE or DONE), the block latches `i_pattern_sel` and `i_num_passes`. It clears `o_pass_cnt`, `o_err_cnt`, `o_err_flag` and `o_first_err_addr`, and sets the pass index p = 0.
- WRITE: one write per cycle.
  - `wr_req` = 1 and `addr` runs 0..MAX_ADDR.
  - `wr_data` = (addr + p) mod 2**DATA_BIT_WIDTH, bitwise inverted when the pattern is 1.
  - addr is zero-extended to DATA_BIT_WIDTH, or truncated if DATA_BIT_WIDTH < ADDR_BIT_WIDTH.
- READ: one read per cycle.
  - `rd_req` = 1 and `addr` runs 0..MAX_ADDR.
  - The expected value and address are pushed into a RD_LATENCY-deep valid/expected/address shift pipeline.
- Compare: when the pipeline output is valid, `rd_data` is compared with the expected value.
  - On a mismatch, the error count is incremented (saturating at all-ones).
  - On the first mismatch, `o_err_flag` is set and `o_first_err_addr` is loaded.
- End of DRAIN:
  - `o_pass_cnt` increments.
  - p increments, wrapping at DATA_BIT_WIDTH.
- `wr_req` and `rd_req` are never high together. Both are low in IDLE, DRAIN and DONE. `addr` and `wr_data` are 0 outside WRITE and READ.
- `i_start` is ignored while `o_busy` is high.
- Reset, including mid-pass:
  - State goes to IDLE and all outputs go to 0.
  - The compare pipeline is flushed, so in-flight reads are never compared.

## Timing
- All outputs are registered. Reset value of every output, including the `if_bus` outputs, is 0.
- Start sampled at edge 0:
  - First write cycle is cycle 1.
  - Writes occupy N = 2**ADDR_BIT_WIDTH cycles; reads occupy the next N cycles.
  - DRAIN occupies RD_LATENCY cycles.
- The compare for the read issued in cycle c uses `rd_data` in cycle c+RD_LATENCY. `o_err_cnt` and `o_err_flag` update at the following edge.
- Pass length is 2N+RD_LATENCY cycles.
- `o_pass_cnt` is visible one cycle after the last DRAIN cycle. The WRITE of the next pass, or DONE, starts in that same cycle, with no gap cycles.
- A final-read mismatch is reflected in `o_err_cnt` no later than the cycle `o_done` rises.

## Test plan
- Defaults, ideal memory with 1-cycle latency, `i_num_passes`=2, pattern 0, start at cycle 0:
  - Pass 0 writes 0,1,2,3 to addresses 0..3 in cycles 1-4, reads in cycles 5-8, DRAIN in cycle 9.
  - Pass 1 writes 1,2,3,4.
  - `o_done` rises at cycle 19 with `o_pass_cnt`=2, `o_err_cnt`=0 and `o_err_flag`=0.
- Pattern 1, one pass: `wr_data` = 0xFF, 0xFE, 0xFD, 0xFC; no errors.
- Slave corrupts address 2 on every read, 3 passes: `o_err_cnt`=3, `o_first_err_addr`=2, `o_err_flag`=1.
- RD_LATENCY=3 with a matching delay in the memory model: pass length is 11 cycles and there are no false errors.
- Reset asserted during READ of pass 1:
  - Next cycle shows all outputs 0 and state IDLE.
  - A subsequent start runs cleanly, with `o_pass_cnt` counting from 0.
- `i_num_passes`=0 (endless), ERR_CNT_WIDTH=2, always-wrong slave:
  - `o_err_cnt` saturates at 3.
  - `o_done` never rises, and `i_start` pulses while busy are ignored.
